vga_timing_gen: RTL and testbench

Raster timing generator for the VGA path. It produces horizontal and vertical pixel counters, sync pulses, an active-video flag, active-area pixel coordinates, and line/frame start strobes. It sits directly upstream of the pixel-control/ROM-lookup stage, which consumes `c1`/`c2`, and of the sync pipeline register in the VGA top level. Every output is registered and mutually consistent in the same cycle.

---
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, active-video,
// active-area coordinates and line/frame strobes, all updated on the same edge.
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] c1,
  output logic [10:0] c2,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HA0    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] VA0    = 11'(V_SYNC + V_BACK);

  // Window bounds kept 12 bits wide so an end bound of exactly 2048 still compares correctly.
  localparam logic [11:0] HS_END = 12'(H_SYNC);
  localparam logic [11:0] VS_END = 12'(V_SYNC);
  localparam logic [11:0] HA_BEG = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HA_END = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] VA_BEG = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VA_END = 12'(V_SYNC + V_BACK + V_ACTIVE);

  logic [10:0] r_c1, r_c2, r_x, r_y;
  logic        r_hsync, r_vsync, r_active, r_line_start, r_frame_start;

  logic [10:0] w_c1_next, w_c2_next;
  logic [11:0] w_c1_ext, w_c2_ext;
  logic        w_active_next;

  always_comb begin
    w_c1_next = (r_c1 == H_LAST) ? 11'd0 : r_c1 + 11'd1;
    w_c2_next = r_c2;
    if (r_c1 == H_LAST) begin
      w_c2_next = (r_c2 == V_LAST) ? 11'd0 : r_c2 + 11'd1;
    end
    w_c1_ext = {1'b0, w_c1_next};
    w_c2_ext = {1'b0, w_c2_next};
    w_active_next = (w_c1_ext >= HA_BEG) && (w_c1_ext < HA_END) &&
                    (w_c2_ext >= VA_BEG) && (w_c2_ext < VA_END);
  end

  // Reset parks on the last front-porch pixel so the first enabled edge starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c1          <= H_LAST;
      r_c2          <= V_LAST;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_x           <= 11'd0;
      r_y           <= 11'd0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_c1          <= w_c1_next;
      r_c2          <= w_c2_next;
      r_hsync       <= (w_c1_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
      r_vsync       <= (w_c2_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
      r_active      <= w_active_next;
      r_x           <= w_active_next ? (w_c1_next - HA0) : 11'd0;
      r_y           <= w_active_next ? (w_c2_next - VA0) : 11'd0;
      r_line_start  <= (w_c1_next == 11'd0);
      r_frame_start <= (w_c1_next == 11'd0) && (w_c2_next == 11'd0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign c1          = r_c1;
  assign c2          = r_c2;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign active      = r_active;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing for the first lines, plus a tiny
// 16x8 raster (active-high sync) for whole-frame, wrap and mid-frame reset cases.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Default-timing instance
  logic        d_rst = 1'b1, d_ce = 1'b0;
  logic [10:0] d_c1, d_c2, d_x, d_y;
  logic        d_hs, d_vs, d_act, d_ls, d_fs;

  vga_timing_gen u_def (
    .clk(clk), .rst(d_rst), .ce(d_ce),
    .c1(d_c1), .c2(d_c2), .hsync(d_hs), .vsync(d_vs), .active(d_act),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  // Small instance: H 4+2+8+2 = 16 (HA0 = 6), V 1+2+4+1 = 8 (VA0 = 3), sync active-high
  logic        s_rst = 1'b1, s_ce = 1'b0;
  logic [10:0] s_c1, s_c2, s_x, s_y;
  logic        s_hs, s_vs, s_act, s_ls, s_fs;

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(s_rst), .ce(s_ce),
    .c1(s_c1), .c2(s_c2), .hsync(s_hs), .vsync(s_vs), .active(s_act),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  initial begin
    int hlow, vlow, cnt, ls_bad, hs_on, vs_on, act_n, ls_n, fs_n, xmax, ymax;

    @(negedge clk);
    tick();
    tick();
    // ---------------- default instance ----------------
    check("rst_c1", int'(d_c1), 799);
    check("rst_c2", int'(d_c2), 524);
    check("rst_hs", int'(d_hs), 1);
    check("rst_vs", int'(d_vs), 1);
    check("rst_act", int'(d_act), 0);
    check("rst_xy", int'(d_x) + int'(d_y), 0);
    check("rst_strobes", int'(d_ls) + int'(d_fs), 0);

    d_rst = 1'b0;
    d_ce  = 1'b1;
    tick();
    check("first_c1", int'(d_c1), 0);
    check("first_c2", int'(d_c2), 0);
    check("first_fs", int'(d_fs), 1);
    check("first_ls", int'(d_ls), 1);
    check("first_hs", int'(d_hs), 0);
    check("first_vs", int'(d_vs), 0);

    hlow = 0;
    vlow = 0;
    for (int i = 0; i < 800; i++) begin
      if (i == 1) check("strobe_1clk", int'(d_ls) + int'(d_fs), 0);
      if (i == 96) check("hs_deassert", int'(d_hs), 1);
      if (!d_hs) hlow++;
      if (!d_vs) vlow++;
      tick();
    end
    check("hs_low_per_line", hlow, 96);
    check("line1_c1", int'(d_c1), 0);
    check("line1_c2", int'(d_c2), 1);
    check("line1_ls", int'(d_ls), 1);
    check("line1_fs", int'(d_fs), 0);

    // From (0,1) to (144,35): 34 lines plus 144 pixels
    for (int i = 0; i < 34 * 800 + 144; i++) begin
      if (!d_vs) vlow++;
      tick();
    end
    check("vs_low_cycles", vlow, 1600);
    check("ha0_c1", int'(d_c1), 144);
    check("va0_c2", int'(d_c2), 35);
    check("ha0_act", int'(d_act), 1);
    check("ha0_x", int'(d_x), 0);
    check("ha0_y", int'(d_y), 0);
    repeat (639) tick();
    check("xmax_c1", int'(d_c1), 783);
    check("xmax_x", int'(d_x), 639);
    check("xmax_act", int'(d_act), 1);
    tick();
    check("hend_act", int'(d_act), 0);
    check("hend_x", int'(d_x), 0);

    // Divide-by-2 enable
    d_ce = 1'b0;
    tick();
    check("hold_c1", int'(d_c1), 784);
    for (int i = 0; i < 15; i++) begin
      d_ce = 1'b1;
      tick();
      d_ce = 1'b0;
      tick();
    end
    check("div2_c1", int'(d_c1), 799);
    d_ce = 1'b1;
    tick();
    check("div2_wrap_c1", int'(d_c1), 0);
    check("div2_wrap_c2", int'(d_c2), 36);
    check("div2_ls", int'(d_ls), 1);
    d_ce = 1'b0;
    tick();
    check("div2_ls_1clk", int'(d_ls), 0);
    check("div2_hold_c1", int'(d_c1), 0);
    // Next line_start lands 1600 clk after the previous one; one clk already elapsed
    cnt = 0;
    ls_bad = 0;
    while (cnt < 4000) begin
      cnt++;
      d_ce = (cnt % 2 == 1);
      tick();
      if (d_ls && !d_ce) ls_bad++;
      if (d_ls) break;
    end
    check("div2_line_period", cnt + 1, 1600);
    check("div2_no_strobe_on_ce0", ls_bad, 0);
    check("div2_c2", int'(d_c2), 37);
    d_ce = 1'b0;

    // ---------------- small instance ----------------
    check("s_rst_c1", int'(s_c1), 15);
    check("s_rst_c2", int'(s_c2), 7);
    check("s_rst_hs", int'(s_hs), 0);
    s_rst = 1'b0;
    s_ce  = 1'b1;
    tick();
    check("s_first_fs", int'(s_fs), 1);
    check("s_first_hs", int'(s_hs), 1);
    check("s_first_vs", int'(s_vs), 1);
    hs_on = 0; vs_on = 0; act_n = 0; ls_n = 0; fs_n = 0; xmax = 0; ymax = 0;
    for (int i = 0; i < 128; i++) begin
      if (s_hs) hs_on++;
      if (s_vs) vs_on++;
      if (s_act) begin
        act_n++;
        if (int'(s_x) > xmax) xmax = int'(s_x);
        if (int'(s_y) > ymax) ymax = int'(s_y);
      end
      if (s_ls) ls_n++;
      if (s_fs) fs_n++;
      tick();
    end
    check("s_hs_on", hs_on, 32);
    check("s_vs_on", vs_on, 16);
    check("s_act_cnt", act_n, 32);
    check("s_ls_cnt", ls_n, 8);
    check("s_fs_cnt", fs_n, 1);
    check("s_xmax", xmax, 7);
    check("s_ymax", ymax, 3);
    check("s_period_fs", int'(s_fs), 1);
    check("s_period_c", int'(s_c1) + int'(s_c2), 0);

    // Mid-frame line wrap (0,0) -> (15,4) -> (0,5)
    repeat (79) tick();
    check("s_pre_wrap_c1", int'(s_c1), 15);
    check("s_pre_wrap_c2", int'(s_c2), 4);
    tick();
    check("s_wrap_c1", int'(s_c1), 0);
    check("s_wrap_c2", int'(s_c2), 5);
    check("s_wrap_ls", int'(s_ls), 1);
    check("s_wrap_fs", int'(s_fs), 0);

    // Move to (9,6) inside the visible area, then reset with ce held high
    repeat (25) tick();
    check("s_mid_act", int'(s_act), 1);
    check("s_mid_x", int'(s_x), 3);
    check("s_mid_y", int'(s_y), 3);
    s_rst = 1'b1;
    tick();
    check("s_mrst_c1", int'(s_c1), 15);
    check("s_mrst_c2", int'(s_c2), 7);
    check("s_mrst_syncs", int'(s_hs) + int'(s_vs), 0);
    check("s_mrst_act", int'(s_act), 0);
    check("s_mrst_strobes", int'(s_ls) + int'(s_fs), 0);
    s_rst = 1'b0;
    tick();
    check("s_restart_c", int'(s_c1) + int'(s_c2), 0);
    check("s_restart_fs", int'(s_fs), 1);
    s_ce = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
